// File: rtl/mc_req_queue.sv
// Multi-channel request queue: one circular FIFO per input channel, round-robin pop output.
// Optional per-channel almost-full flags are built when MC_REQ_QUEUE_AFULL_EN is defined.
module mc_req_queue #(
  parameter  int NUM_CH       = 4,
  parameter  int WIDTH        = 64,
  parameter  int DEPTH        = 4,
  parameter  int AFULL_THRESH = 3,
  localparam int CNT_W        = $clog2(DEPTH + 1),
  localparam int SRC_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]         ch_ready_o,
  input  logic                      pop_i,
  output logic                      empty_o,
  output logic [WIDTH-1:0]          data_o,
  output logic [SRC_W-1:0]          src_o,
  output logic [NUM_CH*CNT_W-1:0]   level_o
`ifdef MC_REQ_QUEUE_AFULL_EN
  ,
  output logic [NUM_CH-1:0]         afull_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop_ch;
  logic [NUM_CH-1:0] nonempty;
  logic [WIDTH-1:0]  head_data [NUM_CH];
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  grant;
  logic              grant_found;
  logic              pop_fire;
  int                sel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0] count_q, count_d;
      logic [WIDTH-1:0] mem_q [DEPTH];

      // Ready comes from the registered count only, so a full channel stays blocked during a pop.
      assign ch_ready_o[gi] = resetn && (count_q < CNT_W'(DEPTH));
      assign push[gi]       = ch_valid_i[gi] && ch_ready_o[gi];
      assign pop_ch[gi]     = pop_fire && (grant == SRC_W'(gi));
      assign nonempty[gi]   = resetn && (count_q != '0);
      assign head_data[gi]  = mem_q[rd_ptr_q];
      assign level_o[gi*CNT_W +: CNT_W] = resetn ? count_q : '0;

      always_comb begin
        count_d = count_q;
        if (push[gi] && !pop_ch[gi]) begin
          count_d = count_q + 1'b1;
        end else if (!push[gi] && pop_ch[gi]) begin
          count_d = count_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          if (push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop_ch[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
          count_q <= count_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) mem_q[wr_ptr_q] <= ch_data_i[gi*WIDTH +: WIDTH];
      end

`ifdef MC_REQ_QUEUE_AFULL_EN
      logic afull_q;
      always_ff @(posedge clk) begin
        if (!resetn) afull_q <= 1'b0;
        else         afull_q <= (count_d >= CNT_W'(AFULL_THRESH));
      end
      assign afull_o[gi] = resetn && afull_q;
`endif
    end
  endgenerate

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    sel_idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_idx = int'(rr_ptr_q) + i;
      if (sel_idx >= NUM_CH) sel_idx = sel_idx - NUM_CH;
      if (!grant_found && nonempty[sel_idx[SRC_W-1:0]]) begin
        grant       = sel_idx[SRC_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  assign empty_o  = !grant_found;
  assign src_o    = grant;
  assign data_o   = head_data[grant];
  assign pop_fire = pop_i && grant_found;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pop_fire) begin
      rr_ptr_d = (grant == SRC_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_mc_req_queue.sv
// Directed bench for mc_req_queue with default parameters; afull checks only when MC_REQ_QUEUE_AFULL_EN is defined.
module tb_mc_req_queue;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 64;
  localparam int CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NUM_CH-1:0]       ch_valid_i;
  logic [NUM_CH*WIDTH-1:0] ch_data_i;
  logic [NUM_CH-1:0]       ch_ready_o;
  logic                    pop_i;
  logic                    empty_o;
  logic [WIDTH-1:0]        data_o;
  logic [1:0]              src_o;
  logic [NUM_CH*CNT_W-1:0] level_o;
`ifdef MC_REQ_QUEUE_AFULL_EN
  logic [NUM_CH-1:0]       afull_o;
`endif

  int vec_cnt     = 0;
  int miscompares = 0;

  mc_req_queue #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ch_valid_i (ch_valid_i),
    .ch_data_i  (ch_data_i),
    .ch_ready_o (ch_ready_o),
    .pop_i      (pop_i),
    .empty_o    (empty_o),
    .data_o     (data_o),
    .src_o      (src_o),
    .level_o    (level_o)
`ifdef MC_REQ_QUEUE_AFULL_EN
    ,
    .afull_o    (afull_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[%0d] %s = %h", vec_cnt, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lvl(input int k);
    return 64'(level_o[k*CNT_W +: CNT_W]);
  endfunction

  task automatic set_data(input int k, input logic [63:0] v);
    ch_data_i[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_one(input int k, input logic [63:0] v);
    ch_valid_i[k] = 1'b1;
    set_data(k, v);
    tick();
    ch_valid_i[k] = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [63:0] src, input logic [63:0] d);
    check({tag, "_src"}, 64'(src_o), src);
    check({tag, "_data"}, data_o, d);
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    ch_valid_i = '0;
    pop_i      = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    ch_valid_i = '0;
    ch_data_i  = '0;
    pop_i      = 1'b0;
    #1;
    check("rst_ready_pre_edge", 64'(ch_ready_o), 64'h0);
    tick();
    tick();
    check("rst_ready_held", 64'(ch_ready_o), 64'h0);
    check("rst_empty_held", 64'(empty_o), 64'h1);
    check("rst_level_held", 64'(level_o), 64'h0);
    check("rst_src_held", 64'(src_o), 64'h0);
    resetn = 1'b1;
    tick();
    check("idle_empty", 64'(empty_o), 64'h1);
    check("idle_ready", 64'(ch_ready_o), 64'hF);
    check("idle_level", 64'(level_o), 64'h0);

    // Single push on ch2, no fall-through in the push cycle
    ch_valid_i[2] = 1'b1;
    set_data(2, 64'hA0);
    #1;
    check("ch2_ready", 64'(ch_ready_o[2]), 64'h1);
    check("ch2_no_fallthru", 64'(empty_o), 64'h1);
    tick();
    ch_valid_i[2] = 1'b0;
    check("ch2_empty", 64'(empty_o), 64'h0);
    check("ch2_level", lvl(2), 64'd1);
    pop_expect("ch2_pop", 64'd2, 64'hA0);
    check("ch2_empty_after", 64'(empty_o), 64'h1);
    check("ch2_level_after", lvl(2), 64'd0);

    // Fill ch1, then hold a fifth beat against backpressure
    for (int i = 0; i < 4; i++) push_one(1, 64'h10 + 64'(i));
    ch_valid_i[1] = 1'b1;
    set_data(1, 64'h14);
    #1;
    check("ch1_full_ready", 64'(ch_ready_o[1]), 64'h0);
    check("ch1_full_level", lvl(1), 64'd4);
    tick();
    tick();
    check("ch1_5th_rejected", lvl(1), 64'd4);
    ch_valid_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) pop_expect("ch1_fifo", 64'd1, 64'h10 + 64'(i));
    check("ch1_drained", 64'(empty_o), 64'h1);
    push_one(1, 64'h20);
    push_one(1, 64'h21);
    pop_expect("ch1_off", 64'd1, 64'h20);
    pop_expect("ch1_off", 64'd1, 64'h21);
    for (int i = 0; i < 4; i++) push_one(1, 64'h22 + 64'(i));
    for (int i = 0; i < 4; i++) pop_expect("ch1_wrap", 64'd1, 64'h22 + 64'(i));
    check("ch1_wrap_empty", 64'(empty_o), 64'h1);

    // Round-robin fairness from a fresh rr pointer
    do_reset();
    ch_valid_i = 4'hF;
    for (int k = 0; k < NUM_CH; k++) set_data(k, 64'h30 + 64'(2 * k));
    tick();
    for (int k = 0; k < NUM_CH; k++) set_data(k, 64'h31 + 64'(2 * k));
    tick();
    ch_valid_i = '0;
    pop_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rr_src", 64'(src_o), 64'(i % 4));
      check("rr_data", data_o, 64'h30 + 64'(2 * (i % 4)) + 64'(i / 4));
      tick();
    end
    pop_i = 1'b0;
    check("rr_empty", 64'(empty_o), 64'h1);

    // Simultaneous push and pop on ch0 keeps its level
    push_one(0, 64'h40);
    push_one(0, 64'h41);
    ch_valid_i[0] = 1'b1;
    set_data(0, 64'h42);
    pop_i = 1'b1;
    #1;
    check("pp_head", data_o, 64'h40);
    tick();
    ch_valid_i[0] = 1'b0;
    check("pp_level", lvl(0), 64'd2);
    check("pp_next", data_o, 64'h41);
    tick();
    check("pp_last", data_o, 64'h42);
    tick();
    check("pp_drained", 64'(empty_o), 64'h1);
    tick();
    tick();
    check("pop_on_empty_level", 64'(level_o), 64'h0);
    check("pop_on_empty_ready", 64'(ch_ready_o), 64'hF);
    pop_i = 1'b0;

    // Reset while entries are stored
    ch_valid_i = 4'b1011;
    set_data(0, 64'h50);
    set_data(1, 64'h51);
    set_data(3, 64'h53);
    tick();
    ch_valid_i = '0;
    check("midrst_stored", 64'(empty_o), 64'h0);
    check("midrst_lvl3", lvl(3), 64'd1);
    resetn = 1'b0;
    #1;
    check("midrst_ready", 64'(ch_ready_o), 64'h0);
    tick();
    resetn = 1'b1;
    #1;
    check("midrst_empty", 64'(empty_o), 64'h1);
    check("midrst_level", 64'(level_o), 64'h0);
    check("midrst_ready_back", 64'(ch_ready_o), 64'hF);

`ifdef MC_REQ_QUEUE_AFULL_EN
    push_one(3, 64'h60);
    push_one(3, 64'h61);
    check("afull_lvl2", 64'(afull_o[3]), 64'h0);
    push_one(3, 64'h62);
    check("afull_lvl3", 64'(afull_o[3]), 64'h1);
    check("afull_level3", lvl(3), 64'd3);
    pop_expect("afull_pop", 64'd3, 64'h60);
    check("afull_fall", 64'(afull_o[3]), 64'h0);
    check("afull_level2", lvl(3), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_req_queue.md
Name: mc_req_queue

Overview:
- Parametrised multi-channel request queue; successor to the single-channel AR/AW/CR queue wrappers.
- NUM_CH independent ACE-style valid/ready request inputs, one from each master port. Each input feeds a private circular FIFO.
- One shared pop-style output. A round-robin arbiter selects the head entry and tags it with its source channel.
- Sits between the master-side ports and the interconnect snoop/dispatch controller.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- WIDTH, 64, payload bits per entry (packed request layout built by the caller).
- DEPTH, 4, entries per channel FIFO. Power of two, >=2.
- AFULL_THRESH, 3, per-channel level at or above which afull_o asserts (optional feature only).
- Derived localparams: CNT_W = $clog2(DEPTH+1); SRC_W = max(1, $clog2(NUM_CH)).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- resetn, input, 1, reset, synchronous and active-low.
- ch_valid_i, input, NUM_CH, per-channel request valid.
- ch_data_i, input, NUM_CH*WIDTH, per-channel payload; channel k occupies bits [k*WIDTH +: WIDTH].
- ch_ready_o, output, NUM_CH, per-channel ready.
- pop_i, input, 1, consumer takes the currently presented entry.
- empty_o, output, 1, no entry presented.
- data_o, output, WIDTH, payload of the presented entry.
- src_o, output, SRC_W, channel index of the presented entry.
- level_o, output, NUM_CH*CNT_W, per-channel occupancy.
- afull_o, output, NUM_CH, per-channel almost-full (present only with MC_REQ_QUEUE_AFULL_EN).

Behaviour:
- Reset (resetn=0 sampled on a clk edge):
  - All write/read pointers, counts and rr_ptr go to 0.
  - While resetn=0, ch_ready_o is forced to 0, empty_o=1, src_o=0, level_o=0 and afull_o=0. data_o is don't-care.
  - A reset arriving mid-operation discards all stored entries; no partial state survives.
- Push:
  - ch_ready_o[k] = resetn && (count[k] < DEPTH), decoded from registered count only.
  - ready does not depend on pop_i: a full channel stays not-ready even if it is being popped that cycle.
  - Push on channel k when ch_valid_i[k] && ch_ready_o[k]. The entry is written at wr_ptr[k], then wr_ptr[k] increments modulo DEPTH (natural wrap).
  - Valid held without ready must not be lost; the payload is sampled only on the handshake cycle.
- Presentation:
  - grant = first channel with count != 0, searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - empty_o = all counts zero. data_o and src_o are combinational from the grant and the head entry (rd_ptr) of that channel.
  - Latency: an entry pushed in cycle N can be presented from cycle N+1. There is no fall-through in the push cycle.
- Pop:
  - When pop_i && !empty_o: rd_ptr[grant] increments modulo DEPTH, and rr_ptr <= (grant+1) mod NUM_CH.
  - pop_i while empty_o=1 is ignored; no state changes.
  - rr_ptr changes only on an accepted pop, so the presented entry stays stable while pop_i=0 (no grant switching while waiting).
- Count:
  - count[k] +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - count never exceeds DEPTH and never underflows.
  - level_o reflects the registered count.
- Fairness: with all channels continuously non-empty, grants rotate 0,1,..,NUM_CH-1,0,...

Optional Feature:
- Macro: MC_REQ_QUEUE_AFULL_EN.
- Defined:
  - afull_o port exists.
  - afull_o[k] = registered (count[k] >= AFULL_THRESH), updated the same cycle as count.
  - Intended for upstream throttling one beat ahead of full.
- Undefined: the afull_o port and its logic are absent; everything else is identical.

Test Plan:
- Reset then idle -> empty_o=1, ch_ready_o=4'b1111, level_o all 0. With resetn held 0: ch_ready_o=0.
- Push 0xA0 on ch2 in cycle N, no pop -> cycle N+1: empty_o=0, src_o=2, data_o=0xA0, level ch2=1. Pop -> empty_o=1, level ch2=0.
- Fill ch1 with 4 entries (0x10..0x13), holding ch_valid_i[1] with a 5th value -> ch_ready_o[1]=0 after the 4th, the 5th is not accepted. Pops return 0x10,0x11,0x12,0x13 in order. Push 4 more to wrap the pointers and confirm order is preserved.
- All 4 channels preloaded with 2 entries each, pop_i=1 continuously -> src_o sequence 0,1,2,3,0,1,2,3, then empty_o=1.
- ch0 at level 2, simultaneous push and pop on ch0 -> level stays 2. pop_i held with everything empty -> no change. Reset asserted with 3 entries stored -> after reset: empty_o=1, all levels 0.
- With MC_REQ_QUEUE_AFULL_EN, AFULL_THRESH=3: pushes on ch3 -> afull_o[3] rises with level 3. One pop drops level to 2 and afull_o[3] falls.
